// File: rtl/rv32i_multicycle_sequencer_if.sv
// Memory handshake bundle between the multi-cycle sequencer and the instruction/data memories.
// The master side issues requests; the slave side returns ready.
interface rv32i_multicycle_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic ir_load;
    logic dmem_req;
    logic dmem_ready;
    logic data_mem_read_enable;
    logic data_mem_write_enable;

    modport master (
        output imem_req,
        output ir_load,
        output dmem_req,
        output data_mem_read_enable,
        output data_mem_write_enable,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  ir_load,
        input  dmem_req,
        input  data_mem_read_enable,
        input  data_mem_write_enable,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/rv32i_multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute/mem/writeback, one instruction at a time.
// Strobes are decoded from the current state; instret and trap are the only registered outputs.
module rv32i_multicycle_sequencer #(
    parameter int INSTRET_WIDTH = 32,
    parameter int MEM_TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run_enable,
    input  logic [6:0]               inst_opcode,
    input  logic                     alu_result_equal_zero,
    rv32i_multicycle_sequencer_if.master mem,
    output logic                     regfile_write_enable,
    output logic                     pc_write_enable,
    output logic [1:0]               next_pc_select,
    output logic [1:0]               reg_writeback_select,
    output logic [2:0]               state,
    output logic [INSTRET_WIDTH-1:0] instret,
    output logic                     trap,
    output logic [1:0]               trap_cause
);
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd6
    } state_e;

    state_e                   state_q, state_d;
    logic [6:0]               opcode_q;
    logic [WAIT_W-1:0]        wait_q, wait_d;
    logic [INSTRET_WIDTH-1:0] instret_q;
    logic                     trap_q;
    logic [1:0]               cause_q, cause_d;
    logic                     retire, trap_set;

    logic imem_req_c, ir_load_c, dmem_req_c, rd_en_c, wr_en_c, rf_we_c, pc_we_c;
    logic [1:0] npc_sel_c, wb_sel_c;

    function automatic logic opcode_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: return 1'b1;
            default:                                                  return 1'b0;
        endcase
    endfunction

    // True in the wait cycle where the low-ready count would reach MEM_TIMEOUT.
    function automatic logic wait_expired(input logic [WAIT_W-1:0] cnt);
        return (MEM_TIMEOUT != 0) && (int'(cnt) == MEM_TIMEOUT - 1);
    endfunction

    always_comb begin
        state_d    = state_q;
        cause_d    = 2'b00;
        trap_set   = 1'b0;
        retire     = 1'b0;
        imem_req_c = 1'b0;
        ir_load_c  = 1'b0;
        dmem_req_c = 1'b0;
        rd_en_c    = 1'b0;
        wr_en_c    = 1'b0;
        rf_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        npc_sel_c  = 2'b00;
        wb_sel_c   = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (run_enable) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (mem.imem_ready) begin
                    ir_load_c = 1'b1;
                    state_d   = S_DECODE;
                end else if (wait_expired(wait_q)) begin
                    state_d  = S_TRAP;
                    trap_set = 1'b1;
                    cause_d  = 2'b10;
                end
            end
            S_DECODE: begin
                if (opcode_legal(inst_opcode)) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d  = S_TRAP;
                    trap_set = 1'b1;
                    cause_d  = 2'b01;
                end
            end
            S_EXECUTE: begin
                case (opcode_q)
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_BRANCH: begin
                        pc_we_c   = 1'b1;
                        npc_sel_c = alu_result_equal_zero ? 2'b01 : 2'b00;
                        retire    = 1'b1;
                    end
                    default: state_d = S_WRITEBACK;
                endcase
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                rd_en_c    = (opcode_q == OP_LOAD);
                wr_en_c    = (opcode_q == OP_STORE);
                if (mem.dmem_ready) begin
                    if (opcode_q == OP_STORE) begin
                        pc_we_c = 1'b1;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (wait_expired(wait_q)) begin
                    state_d  = S_TRAP;
                    trap_set = 1'b1;
                    cause_d  = 2'b11;
                end
            end
            S_WRITEBACK: begin
                rf_we_c = 1'b1;
                pc_we_c = 1'b1;
                retire  = 1'b1;
                case (opcode_q)
                    OP_JAL:  begin npc_sel_c = 2'b10; wb_sel_c = 2'b10; end
                    OP_JALR: begin npc_sel_c = 2'b11; wb_sel_c = 2'b10; end
                    OP_LOAD: wb_sel_c = 2'b01;
                    default: wb_sel_c = 2'b00;
                endcase
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase

        // run_enable only matters at the instruction boundary.
        if (retire) state_d = run_enable ? S_FETCH : S_IDLE;

        wait_d = '0;
        if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM)))
            wait_d = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            wait_q    <= '0;
            instret_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_DECODE) opcode_q <= inst_opcode;
            if (retire) instret_q <= instret_q + INSTRET_WIDTH'(1);
            if (trap_set) begin
                trap_q  <= 1'b1;
                cause_q <= cause_d;
            end
        end
    end

    // Strobes are squelched while reset is held so an abort emits nothing further.
    assign mem.imem_req              = imem_req_c & ~rst;
    assign mem.ir_load               = ir_load_c & ~rst;
    assign mem.dmem_req              = dmem_req_c & ~rst;
    assign mem.data_mem_read_enable  = rd_en_c & ~rst;
    assign mem.data_mem_write_enable = wr_en_c & ~rst;
    assign regfile_write_enable      = rf_we_c & ~rst;
    assign pc_write_enable           = pc_we_c & ~rst;
    assign next_pc_select            = npc_sel_c & {2{~rst}};
    assign reg_writeback_select      = wb_sel_c & {2{~rst}};
    assign state                     = state_q;
    assign instret                   = instret_q;
    assign trap                      = trap_q;
    assign trap_cause                = cause_q;
endmodule

// File: tb/tb_rv32i_multicycle_sequencer.sv
// Randomized bench for the multi-cycle sequencer: a per-instruction script predicts every cycle's outputs.
module tb_rv32i_multicycle_sequencer;
    localparam int IW  = 4;
    localparam int TMO = 4;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3;
    localparam int ST_MEM = 4, ST_WB = 5, ST_TRAP = 6;

    localparam logic [6:0] R_T = 7'b0110011, I_T = 7'b0010011, LD = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

    logic          clk = 1'b0, rst = 1'b1, run_enable = 1'b0, zero = 1'b0;
    logic [6:0]    opcode = '0;
    logic          regfile_write_enable, pc_write_enable, trap;
    logic [1:0]    next_pc_select, reg_writeback_select, trap_cause;
    logic [2:0]    state;
    logic [IW-1:0] instret;

    rv32i_multicycle_sequencer_if mif();

    rv32i_multicycle_sequencer #(.INSTRET_WIDTH(IW), .MEM_TIMEOUT(TMO)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .run_enable            (run_enable),
        .inst_opcode           (opcode),
        .alu_result_equal_zero (zero),
        .mem                   (mif),
        .regfile_write_enable  (regfile_write_enable),
        .pc_write_enable       (pc_write_enable),
        .next_pc_select        (next_pc_select),
        .reg_writeback_select  (reg_writeback_select),
        .state                 (state),
        .instret               (instret),
        .trap                  (trap),
        .trap_cause            (trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    st;
        logic          ireq, irl, dreq, rd, wr, rfwe, pcwe;
        logic [1:0]    nps, wbs;
        logic [IW-1:0] ir;
        logic          tr;
        logic [1:0]    tc;
    } vec_t;

    vec_t          exp_q;
    bit            exp_v = 1'b0;
    bit            lit_v = 1'b0;
    string         lit_name = "";
    logic [IW-1:0] lit_ir = '0;
    logic [2:0]    lit_tc = '0;
    int            total = 0, bad = 0;

    logic [IW-1:0] instret_m = '0;
    logic          trap_m = 1'b0;
    logic [1:0]    cause_m = 2'b00;

    logic [6:0] LEGAL [7] = '{R_T, I_T, LD, SW, BR, JAL, JALR};

    always @(negedge clk) begin
        vec_t got;
        got.st = state; got.ireq = mif.imem_req; got.irl = mif.ir_load;
        got.dreq = mif.dmem_req; got.rd = mif.data_mem_read_enable;
        got.wr = mif.data_mem_write_enable; got.rfwe = regfile_write_enable;
        got.pcwe = pc_write_enable; got.nps = next_pc_select; got.wbs = reg_writeback_select;
        got.ir = instret; got.tr = trap; got.tc = trap_cause;
        if (exp_v) begin
            total++;
            if (got !== exp_q) begin
                bad++;
                $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, got, exp_q);
            end
        end
        if (lit_v) begin
            total++;
            if ({instret, trap, trap_cause} !== {lit_ir, lit_tc}) begin
                bad++;
                $display("FAIL %s instret/trap/cause got=%0d/%0b/%0d want=%0d/%0b/%0d",
                         lit_name, instret, trap, trap_cause, lit_ir, lit_tc[2], lit_tc[1:0]);
            end
        end
    end

    function automatic bit legal(input logic [6:0] op);
        foreach (LEGAL[i]) if (LEGAL[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] rnd7();
        return 7'($urandom);
    endfunction

    function automatic vec_t mk(input int st, input bit ireq, irl, dreq, rd, wr, rfwe, pcwe,
                                input int nps, input int wbs);
        vec_t v;
        v.st = 3'(st); v.ireq = ireq; v.irl = irl; v.dreq = dreq; v.rd = rd; v.wr = wr;
        v.rfwe = rfwe; v.pcwe = pcwe; v.nps = 2'(nps); v.wbs = 2'(wbs);
        v.ir = instret_m; v.tr = trap_m; v.tc = cause_m;
        return v;
    endfunction

    function automatic vec_t quiet(input int st);
        return mk(st, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Drive one cycle's inputs and its predicted outputs; returns at the next posedge + 1.
    task automatic step(input logic [6:0] op, input logic z, ir, dr, run, input vec_t e);
        opcode = op; zero = z; mif.imem_ready = ir; mif.dmem_ready = dr; run_enable = run;
        exp_q = e; exp_v = 1'b1;
        @(posedge clk); #1;
        lit_v = 1'b0;
    endtask

    task automatic retire_step(input logic [6:0] op, input logic z, ir, dr, input vec_t e,
                               output bit run);
        run = (($urandom % 4) != 0);
        step(op, z, ir, dr, run, e);
        instret_m = IW'((int'(instret_m) + 1) % (1 << IW));
    endtask

    task automatic pin(input string name, input int ir, input int tc);
        lit_name = name; lit_ir = IW'(ir); lit_tc = 3'(tc); lit_v = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1; exp_v = 1'b0; run_enable = 1'b0;
        mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0;
        @(posedge clk); #1;
        instret_m = '0; trap_m = 1'b0; cause_m = 2'b00;
        exp_q = quiet(ST_IDLE); exp_v = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; exp_v = 1'b0;
    endtask

    task automatic idle_then_go(input int n);
        repeat (n) step(rnd7(), rbit(), rbit(), rbit(), 1'b0, quiet(ST_IDLE));
        step(rnd7(), rbit(), rbit(), rbit(), 1'b1, quiet(ST_IDLE));
    endtask

    task automatic trap_hold(input int n);
        repeat (n) step(rnd7(), rbit(), rbit(), rbit(), 1'b1, quiet(ST_TRAP));
    endtask

    // Script of one instruction from its first fetch cycle. res: 0 retired, 1 trapped, 2 reset.
    task automatic run_instr(input logic [6:0] op, input int idly, input int ddly, input logic z,
                             input int rst_k, output int res, output bit run);
        bit   rdy;
        vec_t e;
        int   nps, wbs;
        res = 0; run = 1'b0;
        for (int k = 0; k < 64; k++) begin
            rdy = (k == idly);
            step(rnd7(), rbit(), rdy, rbit(), rbit(), mk(ST_FETCH, 1, rdy, 0, 0, 0, 0, 0, 0, 0));
            if (rdy) break;
            if (k + 1 == TMO) begin trap_m = 1'b1; cause_m = 2'b10; res = 1; return; end
        end
        step(op, rbit(), rbit(), rbit(), rbit(), quiet(ST_DECODE));
        if (!legal(op)) begin trap_m = 1'b1; cause_m = 2'b01; res = 1; return; end
        if (op == BR) begin
            retire_step(rnd7(), z, rbit(), rbit(), mk(ST_EXEC, 0, 0, 0, 0, 0, 0, 1, z ? 1 : 0, 0), run);
            return;
        end
        step(rnd7(), rbit(), rbit(), rbit(), rbit(), quiet(ST_EXEC));
        if (op == LD || op == SW) begin
            for (int k = 0; k < 64; k++) begin
                if (k == rst_k) begin do_reset(); res = 2; return; end
                rdy = (k == ddly);
                e = mk(ST_MEM, 0, 0, 1, op == LD, op == SW, 0, rdy && op == SW, 0, 0);
                if (rdy && op == SW) begin
                    retire_step(rnd7(), rbit(), rbit(), 1'b1, e, run);
                    return;
                end
                step(rnd7(), rbit(), rbit(), rdy, rbit(), e);
                if (rdy) break;
                if (k + 1 == TMO) begin trap_m = 1'b1; cause_m = 2'b11; res = 1; return; end
            end
        end
        nps = (op == JAL) ? 2 : (op == JALR) ? 3 : 0;
        wbs = (op == LD) ? 1 : (op == JAL || op == JALR) ? 2 : 0;
        retire_step(rnd7(), rbit(), rbit(), rbit(), mk(ST_WB, 0, 0, 0, 0, 0, 1, 1, nps, wbs), run);
    endtask

    task automatic after(input int res, input bit run);
        if (res == 1) begin
            trap_hold($urandom_range(1, 3));
            do_reset();
            idle_then_go($urandom_range(0, 2));
        end else if (res == 2) begin
            idle_then_go($urandom_range(0, 2));
        end else if (!run) begin
            idle_then_go($urandom_range(0, 2));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         res;
        bit         run;
        logic [6:0] op;
        int         idly, ddly;
        mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0;
        #1;
        do_reset();
        idle_then_go(2);

        run_instr(R_T, 0, 0, 1'b0, -1, res, run);  pin("rtype_retire", 1, 0);  after(res, run);
        run_instr(LD, 0, 3, 1'b0, -1, res, run);   pin("load_retire", 2, 0);   after(res, run);
        run_instr(BR, 0, 0, 1'b1, -1, res, run);   pin("branch_taken", 3, 0);  after(res, run);
        run_instr(BR, 1, 0, 1'b0, -1, res, run);   pin("branch_nt", 4, 0);     after(res, run);
        run_instr(JAL, 2, 0, 1'b0, -1, res, run);                              after(res, run);
        run_instr(JALR, 0, 0, 1'b0, -1, res, run); pin("jal_jalr", 6, 0);      after(res, run);
        run_instr(SW, 0, 2, 1'b0, -1, res, run);   pin("store_retire", 7, 0);  after(res, run);

        run_instr(7'b1111111, 0, 0, 1'b0, -1, res, run);
        pin("illegal_trap", 7, 3'b101);
        trap_hold(20);
        do_reset();
        pin("after_reset", 0, 0);
        idle_then_go(0);

        run_instr(R_T, 4, 0, 1'b0, -1, res, run);
        pin("imem_timeout", 0, 3'b110);
        trap_hold(3);
        do_reset();
        idle_then_go(0);

        run_instr(I_T, 3, 0, 1'b0, -1, res, run);  pin("ready_on_last_wait", 1, 0); after(res, run);

        run_instr(LD, 0, 4, 1'b0, -1, res, run);
        pin("dmem_timeout", 1, 3'b111);
        trap_hold(3);
        do_reset();
        idle_then_go(0);

        run_instr(SW, 0, 5, 1'b0, 2, res, run);
        pin("reset_in_mem", 0, 0);
        after(res, run);

        for (int n = 0; n < 300; n++) begin
            if (($urandom % 12) == 0) begin
                op = rnd7();
                for (int t = 0; t < 16 && legal(op); t++) op = rnd7();
                if (legal(op)) op = 7'b1111111;
            end else begin
                op = LEGAL[$urandom % 7];
            end
            idly = (($urandom % 16) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
            ddly = (($urandom % 16) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
            run_instr(op, idly, ddly, rbit(), -1, res, run);
            after(res, run);
        end

        exp_v = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rv32i_multicycle_sequencer.md
Name: rv32i_multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences one RV32I instruction at a time through the existing datapath: fetch, decode, execute, memory, writeback.
- Drives the instruction and data memory request handshakes and gates the datapath write enables per step.
- Selects the next-PC source and the writeback source, counts retired instructions, and raises a sticky trap on illegal opcodes or memory timeouts.

Parameters:
- INSTRET_WIDTH, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 255, maximum wait cycles for imem_ready or dmem_ready before trapping. 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run_enable  in  1  allows leaving IDLE; sampled at instruction boundaries.
- inst_opcode  in  7  opcode field from the instruction register.
- alu_result_equal_zero  in  1  ALU zero flag.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  load the instruction register.
- dmem_req  out  1  data memory request.
- data_mem_read_enable  out  1  load access.
- data_mem_write_enable  out  1  store access.
- regfile_write_enable  out  1  register file write strobe.
- pc_write_enable  out  1  PC update strobe.
- next_pc_select  out  2  00 = PC+4, 01 = PC+imm (branch), 10 = PC+imm (JAL), 11 = rs1+imm (JALR).
- reg_writeback_select  out  2  00 = ALU, 01 = memory, 10 = PC+4.
- state  out  3  current state, for debug.
- instret  out  INSTRET_WIDTH  retired-instruction count.
- trap  out  1  sticky error flag.
- trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = imem timeout, 11 = dmem timeout.

Behaviour:
- State encoding: IDLE = 0, FETCH = 1, DECODE = 2, EXECUTE = 3, MEM = 4, WRITEBACK = 5, TRAP = 6.
- Reset: state = IDLE. instret = 0, trap = 0, trap_cause = 00, wait counter = 0, latched opcode = 0. Every strobe output is 0 and both selects are 00. Reset mid-operation aborts immediately with no further strobes.
- Outputs are combinational from state, the latched opcode and the ready inputs. The two exceptions are registered: instret and trap/trap_cause.
- IDLE: go to FETCH when run_enable = 1.
- FETCH:
  - imem_req = 1 and is held until imem_ready.
  - In the imem_ready cycle: ir_load = 1, next state DECODE.
  - ir_load is never asserted without imem_ready.
- DECODE: one cycle; latch inst_opcode.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111.
  - Legal -> EXECUTE. Any other opcode -> TRAP, cause 01.
- EXECUTE: one cycle.
  - Load or store -> MEM.
  - Branch: pc_write_enable = 1; next_pc_select = 01 if alu_result_equal_zero, else 00. The instruction retires and goes to FETCH.
  - R, I-ALU, JAL, JALR -> WRITEBACK.
- MEM:
  - dmem_req = 1 is held until dmem_ready. data_mem_read_enable is 1 for a load and data_mem_write_enable is 1 for a store, both held for the whole MEM state.
  - Store, on dmem_ready: pc_write_enable = 1, select 00, retire, go to FETCH.
  - Load, on dmem_ready: go to WRITEBACK.
- WRITEBACK: one cycle. regfile_write_enable = 1 and pc_write_enable = 1, then retire.
  - next_pc_select: JAL 10, JALR 11, otherwise 00.
  - reg_writeback_select: load 01, JAL/JALR 10, otherwise 00.
- Retire:
  - instret increments by 1 on the retire cycle and wraps modulo 2^INSTRET_WIDTH.
  - Next state is FETCH if run_enable = 1, otherwise IDLE.
  - Deasserting run_enable mid-instruction never truncates the instruction.
- Timeout:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle ready is low.
  - When the counter reaches MEM_TIMEOUT with ready still low: go to TRAP with cause 10 (FETCH) or 11 (MEM). Request outputs drop on the next cycle.
  - Ready arriving in the same cycle the count reaches MEM_TIMEOUT wins, so no trap.
- TRAP: all strobes 0. trap and cause hold until rst. No retire; run_enable is ignored.
- Exactly one pc_write_enable pulse per retired instruction, in the retire cycle.

Test Plan:
- R-type 0110011 with imem_ready on its first cycle:
  - FETCH -> DECODE -> EXECUTE -> WRITEBACK, 4 cycles after leaving IDLE.
  - regfile_write_enable pulses once with reg_writeback_select 00 and next_pc_select 00.
  - instret goes 0 -> 1.
- Load 0000011 with dmem_ready delayed 3 cycles:
  - dmem_req and data_mem_read_enable stay high for 4 cycles.
  - Followed by WRITEBACK with reg_writeback_select 01; instret +1.
- Branch 1100011:
  - zero = 1 -> single pc_write_enable with next_pc_select 01, no regfile write.
  - Repeat with zero = 0 -> next_pc_select 00.
- JAL 1101111 then JALR 1100111:
  - WRITEBACK next_pc_select 10, then 11.
  - reg_writeback_select 10 both times.
- Opcode 1111111 -> TRAP:
  - trap = 1, trap_cause = 01, instret unchanged.
  - Stays in TRAP for 20 cycles with run_enable = 1; rst clears to IDLE.
- MEM_TIMEOUT = 4 with imem_ready stuck low:
  - TRAP with cause 10 after 4 wait cycles.
  - Same setup with imem_ready rising on the 4th wait cycle -> no trap.
  - Assert rst during MEM -> next cycle IDLE with all outputs 0.
